// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: two half-subtractor cells plus a borrow flop form a
// full subtractor that is stepped LSB-first over WIDTH cycles per operation.

module half_subtractor (
    input  logic i_a,
    input  logic i_b,
    output logic o_diff,
    output logic o_borrow
);
    assign o_diff   = i_a ^ i_b;
    assign o_borrow = ~i_a & i_b;
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sx;
    logic [WIDTH-1:0] r_sy;
    logic [WIDTH-1:0] r_acc;
    logic             r_br;
    logic [CW-1:0]    r_count;

    logic             w_t;
    logic             w_b1;
    logic             w_dbit;
    logic             w_b2;
    logic             w_br_next;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    half_subtractor u_cell1 (
        .i_a      (r_sx[0]),
        .i_b      (r_sy[0]),
        .o_diff   (w_t),
        .o_borrow (w_b1)
    );

    half_subtractor u_cell2 (
        .i_a      (w_t),
        .i_b      (r_br),
        .o_diff   (w_dbit),
        .o_borrow (w_b2)
    );

    assign w_br_next = w_b1 | w_b2;
    assign w_last    = (r_count == CW'(WIDTH - 1));

    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_next = w_dbit;
        end else begin : g_acc_wn
            assign w_acc_next = {w_dbit, r_acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sx    <= '0;
            r_sy    <= '0;
            r_acc   <= '0;
            r_br    <= 1'b0;
            r_count <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            d       <= '0;
            b       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sx    <= x;
                        r_sy    <= y;
                        r_br    <= 1'b0;
                        r_acc   <= '0;
                        r_count <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_br    <= w_br_next;
                    r_acc   <= w_acc_next;
                    r_sx    <= r_sx >> 1;
                    r_sy    <= r_sy >> 1;
                    r_count <= r_count + CW'(1);
                    // The final step's bit is folded straight into d so DONE needs no extra cycle.
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        d       <= w_acc_next;
                        b       <= w_br_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
